// File: rtl/tdc_capture_array.sv
// Multi-channel gated event counter: per-channel sync/debounce/edge front end, windowed
// counting, and a snapshot result register with valid/ack handshake and overrun flag.
module tdc_capture_array #(
    parameter int N_CH      = 4,
    parameter int CNT_BITS  = 8,
    parameter int WIN_BITS  = 10,
    parameter int SYNC_BITS = 2,
    parameter int DEB_BITS  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       continuous,
    input  logic [WIN_BITS-1:0]        window_len,
    input  logic [N_CH-1:0]            pulse_in,
    input  logic                       result_ack,
    output logic                       busy,
    output logic                       result_valid,
    output logic [N_CH*CNT_BITS-1:0]   result_data,
    output logic [N_CH-1:0]            overflow,
    output logic                       overrun
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_CLEAR | one cycle: zero counters, latch window length
    // S_RUN   | counting debounced rising edges for win_q cycles
    // S_DONE  | one cycle: snapshot counters into result regs
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [N_CH-1:0][SYNC_BITS-1:0] sync_q, sync_d;
    logic [N_CH-1:0][DEB_BITS-1:0]  deb_sr_q, deb_sr_d;
    logic [N_CH-1:0]                prev_q, prev_d;
    logic [N_CH-1:0]                deb, inc;

    logic [N_CH-1:0][CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]                sat_q, sat_d;
    logic [WIN_BITS-1:0]            win_q, win_d;
    logic [WIN_BITS-1:0]            win_cnt_q, win_cnt_d;

    logic [N_CH-1:0][CNT_BITS-1:0]  res_q, res_d;
    logic [N_CH-1:0]                ovf_q, ovf_d;
    logic                           valid_q, valid_d;
    logic                           overrun_q, overrun_d;

    // Front end runs in every state; only the counters are gated by the FSM.
    always_comb begin
        sync_d   = sync_q;
        deb_sr_d = deb_sr_q;
        deb      = '0;
        inc      = '0;
        for (int i = 0; i < N_CH; i++) begin
            sync_d[i]   = {sync_q[i][SYNC_BITS-2:0], pulse_in[i]};
            deb_sr_d[i] = DEB_BITS'({deb_sr_q[i], sync_q[i][SYNC_BITS-1]});
            deb[i]      = &deb_sr_q[i];
            inc[i]      = deb[i] & ~prev_q[i];
        end
        prev_d = deb;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        win_d     = win_q;
        win_cnt_d = win_cnt_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // An ack landing on the snapshot cycle keeps valid high for the new data.
        if (state_q == S_DONE && !abort) begin
            res_d   = cnt_q;
            ovf_d   = sat_q;
            valid_d = 1'b1;
            if (valid_q && !result_ack) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && result_ack) begin
            valid_d = 1'b0;
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_CLEAR;
                        overrun_d = 1'b0;
                    end
                end
                S_CLEAR: begin
                    cnt_d     = '0;
                    sat_d     = '0;
                    win_d     = (window_len == '0) ? WIN_BITS'(1) : window_len;
                    win_cnt_d = '0;
                    state_d   = S_RUN;
                end
                S_RUN: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (inc[i]) begin
                            if (cnt_q[i] == {CNT_BITS{1'b1}}) begin
                                sat_d[i] = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
                            end
                        end
                    end
                    win_cnt_d = win_cnt_q + WIN_BITS'(1);
                    if (win_cnt_q == win_q - WIN_BITS'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = continuous ? S_CLEAR : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync_q    <= '0;
            deb_sr_q  <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            sat_q     <= '0;
            win_q     <= '0;
            win_cnt_q <= '0;
            res_q     <= '0;
            ovf_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            deb_sr_q  <= deb_sr_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            win_q     <= win_d;
            win_cnt_q <= win_cnt_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = valid_q;
    assign result_data  = res_q;
    assign overflow     = ovf_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tdc_capture_array.sv
// Bench for tdc_capture_array: directed measurements checked every cycle against a
// behavioural model, plus hand-computed result values. Narrow counters make saturation reachable.
module tb_tdc_capture_array;

    localparam int N_CH      = 4;
    localparam int CNT_BITS  = 4;
    localparam int WIN_BITS  = 10;
    localparam int SYNC_BITS = 2;
    localparam int DEB_BITS  = 3;
    localparam int HL        = SYNC_BITS + DEB_BITS + 1;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DONE = 3;

    logic                     clk, rst, start, abort, continuous, result_ack;
    logic [WIN_BITS-1:0]      window_len;
    logic [N_CH-1:0]          pulse_in;
    logic                     busy, result_valid, overrun;
    logic [N_CH*CNT_BITS-1:0] result_data;
    logic [N_CH-1:0]          overflow;

    int checks = 0;
    int failures = 0;
    int busy_total = 0;
    int b0;

    // model state
    logic [N_CH-1:0] hist [HL];
    int              m_ph, m_remain;
    int              m_cnt [N_CH];
    int              m_res [N_CH];
    logic [N_CH-1:0] m_sat, m_ovf;
    logic            m_valid, m_overrun;

    tdc_capture_array #(
        .N_CH(N_CH), .CNT_BITS(CNT_BITS), .WIN_BITS(WIN_BITS),
        .SYNC_BITS(SYNC_BITS), .DEB_BITS(DEB_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
        .window_len(window_len), .pulse_in(pulse_in), .result_ack(result_ack),
        .busy(busy), .result_valid(result_valid), .result_data(result_data),
        .overflow(overflow), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < HL; j++) hist[j] = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c] = 0;
            m_res[c] = 0;
        end
        m_sat = '0; m_ovf = '0; m_valid = 1'b0; m_overrun = 1'b0;
        m_ph = P_IDLE; m_remain = 0;
    endtask

    // An event counts once: the first cycle the input has been seen high for
    // DEB_BITS consecutive samples, delayed by the synchronizer depth.
    task automatic model_step();
        logic [N_CH-1:0] incv;
        bit dn, dp;
        for (int c = 0; c < N_CH; c++) begin
            dn = 1'b1; dp = 1'b1;
            for (int j = SYNC_BITS; j < SYNC_BITS + DEB_BITS; j++) dn = dn & hist[j][c];
            for (int j = SYNC_BITS + 1; j <= SYNC_BITS + DEB_BITS; j++) dp = dp & hist[j][c];
            incv[c] = dn & ~dp;
        end
        if (!(m_ph == P_DONE && !abort) && m_valid && result_ack) m_valid = 1'b0;
        if (abort) begin
            m_ph = P_IDLE;
        end else begin
            case (m_ph)
                P_IDLE: if (start) begin
                    m_ph = P_CLEAR;
                    m_overrun = 1'b0;
                end
                P_CLEAR: begin
                    for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
                    m_sat = '0;
                    m_remain = (window_len == 0) ? 1 : int'(window_len);
                    m_ph = P_RUN;
                end
                P_RUN: begin
                    for (int c = 0; c < N_CH; c++)
                        if (incv[c]) begin
                            if (m_cnt[c] == (1 << CNT_BITS) - 1) m_sat[c] = 1'b1;
                            else m_cnt[c] = m_cnt[c] + 1;
                        end
                    m_remain = m_remain - 1;
                    if (m_remain == 0) m_ph = P_DONE;
                end
                default: begin
                    if (m_valid && !result_ack) m_overrun = 1'b1;
                    m_res = m_cnt;
                    m_ovf = m_sat;
                    m_valid = 1'b1;
                    m_ph = continuous ? P_CLEAR : P_IDLE;
                end
            endcase
        end
        for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = pulse_in;
    endtask

    function automatic logic [N_CH*CNT_BITS-1:0] model_data();
        logic [N_CH*CNT_BITS-1:0] d;
        d = '0;
        for (int c = 0; c < N_CH; c++) d[c*CNT_BITS +: CNT_BITS] = m_res[c][CNT_BITS-1:0];
        return d;
    endfunction

    task automatic compare_all();
        check("busy", busy, m_ph != P_IDLE);
        check("result_valid", result_valid, m_valid);
        check("result_data", result_data, model_data());
        check("overflow", overflow, m_ovf);
        check("overrun", overrun, m_overrun);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_all();
            if (busy) busy_total++;
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
            #2;
        end
    endtask

    task automatic pulse(input int ch, input int hi, input int lo);
        pulse_in[ch] = 1'b1;
        tick(hi);
        pulse_in[ch] = 1'b0;
        tick(lo);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (busy && n < budget);
        check("wait_idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_signal(input int which, input int budget);
        int n;
        logic s;
        n = 0;
        do begin
            tick(1);
            n++;
            s = (which == 0) ? result_valid : overrun;
        end while (!s && n < budget);
        check("wait_signal_timeout", s, 1'b1);
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
        check("ack_clears_valid", result_valid, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        start = 0; abort = 0; continuous = 0; result_ack = 0;
        window_len = '0; pulse_in = '0;
        rst = 1'b1;
        model_reset();
        tick(3);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", result_valid, 1'b0);
        rst = 1'b0;
        tick(2);

        // 1: five clean pulses on ch0 in a 100-cycle window
        window_len = 10'd100;
        b0 = busy_total;
        do_start();
        tick(3);
        repeat (5) pulse(0, 4, 4);
        wait_idle(200);
        check("t1_busy_cycles", busy_total - b0, 102);
        check("t1_valid", result_valid, 1'b1);
        check("t1_data", result_data, 16'h0005);
        check("t1_overflow", overflow, 4'b0000);
        do_ack();

        // 2: short glitch rejected, 3-cycle pulse counted
        do_start();
        tick(3);
        pulse(1, 2, 3);
        pulse(1, 3, 4);
        wait_idle(200);
        check("t2_data", result_data, 16'h0010);

        // 6b: abort mid-run leaves previous result intact
        do_start();
        tick(3);
        repeat (2) pulse(0, 4, 4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", result_valid, 1'b1);
        check("abort_data", result_data, 16'h0010);
        tick(2);
        check("abort_stays_idle", busy, 1'b0);
        do_ack();

        // 3: saturation on ch2
        window_len = 10'd400;
        do_start();
        tick(3);
        repeat (20) pulse(2, 4, 4);
        wait_idle(500);
        check("t3_data", result_data, 16'h0F00);
        check("t3_overflow", overflow, 4'b0100);
        do_ack();

        // 4a: continuous, no ack -> second snapshot sets overrun
        window_len = 10'd50;
        continuous = 1'b1;
        do_start();
        tick(3);
        pulse(3, 4, 4);
        wait_signal(0, 100);
        check("t4_first_data", result_data, 16'h1000);
        check("t4_first_overrun", overrun, 1'b0);
        repeat (2) pulse(3, 4, 4);
        wait_signal(1, 100);
        check("t4_second_data", result_data, 16'h2000);
        check("t4_second_valid", result_valid, 1'b1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t4_overrun_sticky", overrun, 1'b1);

        // 4b: ack pulsed exactly in each DONE cycle -> no overrun, valid stays high
        do_start();
        check("t4_overrun_cleared", overrun, 1'b0);
        tick(51);
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
        check("t4b_valid1", result_valid, 1'b1);
        check("t4b_overrun1", overrun, 1'b0);
        check("t4b_data1", result_data, 16'h0000);
        tick(51);
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
        check("t4b_valid2", result_valid, 1'b1);
        check("t4b_overrun2", overrun, 1'b0);
        abort = 1'b1;
        continuous = 1'b0;
        tick(1);
        abort = 1'b0;
        do_ack();

        // 5: zero window -> one RUN cycle; start held through RUN is ignored
        window_len = 10'd0;
        b0 = busy_total;
        start = 1'b1;
        tick(3);
        start = 1'b0;
        tick(3);
        check("t5_busy_cycles", busy_total - b0, 3);
        check("t5_idle", busy, 1'b0);
        check("t5_valid", result_valid, 1'b1);

        // 6a: reset mid-run clears everything
        window_len = 10'd100;
        do_start();
        tick(10);
        rst = 1'b1;
        model_reset();
        tick(1);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_data", result_data, 16'h0000);
        check("rst_overflow", overflow, 4'b0000);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        tick(2);
        check("post_rst_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
